// File: rtl/fe_pkg.sv
// Shared RV32I front-end types: opcodes, mnemonics, field typedefs,
// funct3/funct7 constants and the program-loader FSM state encoding.
package fe_pkg;

    typedef logic [4:0]  reg_idx_t;
    typedef logic [31:0] word_t;
    typedef logic [2:0]  funct3_t;
    typedef logic [6:0]  funct7_t;

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_IMM    = 7'b0010011,
        OP_AUIPC  = 7'b0010111,
        OP_STORE  = 7'b0100011,
        OP_REG    = 7'b0110011,
        OP_LUI    = 7'b0110111,
        OP_BRANCH = 7'b1100011,
        OP_JALR   = 7'b1100111,
        OP_JAL    = 7'b1101111,
        OP_SYSTEM = 7'b1110011
    } rv32i_opcode_t;

    typedef enum logic [5:0] {
        NULL,
        LUI, AUIPC, JAL, JALR,
        BEQ, BNE, BLT, BGE, BLTU, BGEU,
        LB, LH, LW, LBU, LHU,
        SB, SH, SW,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        ECALL, EBREAK
    } RV32I_INSTRUCTION_MNEMONIC_t;

    // Instruction layout class chosen by the encoder's decode stage.
    typedef enum logic [3:0] {
        FMT_NONE, FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_J, FMT_U, FMT_SYS
    } inst_fmt_t;

    typedef enum logic [2:0] {
        IDLE, ACCEPT, ENCODE, WRITE, DONE
    } loader_state_t;

    // funct3: branches
    localparam funct3_t F3_BEQ  = 3'b000;
    localparam funct3_t F3_BNE  = 3'b001;
    localparam funct3_t F3_BLT  = 3'b100;
    localparam funct3_t F3_BGE  = 3'b101;
    localparam funct3_t F3_BLTU = 3'b110;
    localparam funct3_t F3_BGEU = 3'b111;
    // funct3: loads and stores (byte/half/word, unsigned variants)
    localparam funct3_t F3_B    = 3'b000;
    localparam funct3_t F3_H    = 3'b001;
    localparam funct3_t F3_W    = 3'b010;
    localparam funct3_t F3_BU   = 3'b100;
    localparam funct3_t F3_HU   = 3'b101;
    // funct3: ALU operations, shared by register and immediate forms
    localparam funct3_t F3_ADD  = 3'b000;
    localparam funct3_t F3_SLL  = 3'b001;
    localparam funct3_t F3_SLT  = 3'b010;
    localparam funct3_t F3_SLTU = 3'b011;
    localparam funct3_t F3_XOR  = 3'b100;
    localparam funct3_t F3_SR   = 3'b101;
    localparam funct3_t F3_OR   = 3'b110;
    localparam funct3_t F3_AND  = 3'b111;
    localparam funct3_t F3_JALR = 3'b000;

    localparam funct7_t F7_BASE = 7'b0000000;
    localparam funct7_t F7_ALT  = 7'b0100000;

    localparam word_t ECALL_WORD  = 32'h0000_0073;
    localparam word_t EBREAK_WORD = 32'h0010_0073;

    // True when v, read as signed, fits in a 'bits'-wide signed field.
    function automatic logic fits_signed(input word_t v, input int unsigned bits);
        word_t s;
        s = word_t'($signed(v) >>> (bits - 1));
        return (s == '0) || (s == '1);
    endfunction

endpackage

// File: rtl/rv32i_inst_encoder.sv
// Combinational RV32I encoder: mnemonic plus operand fields to a 32-bit
// instruction word, with an invalid flag for unencodable descriptors.
module rv32i_inst_encoder
    import fe_pkg::*;
(
    input  RV32I_INSTRUCTION_MNEMONIC_t mnemonic,
    input  reg_idx_t                    rd,
    input  reg_idx_t                    rs1,
    input  reg_idx_t                    rs2,
    input  word_t                       imm,
    output word_t                       word,
    output logic                        invalid
);

    inst_fmt_t     fmt;
    rv32i_opcode_t op;
    funct3_t       f3;
    funct7_t       f7;

    // Decode the mnemonic into layout class, opcode and function fields.
    always_comb begin
        fmt = FMT_NONE;
        op  = OP_REG;
        f3  = F3_ADD;
        f7  = F7_BASE;
        case (mnemonic)
            LUI:    begin fmt = FMT_U; op = OP_LUI;   end
            AUIPC:  begin fmt = FMT_U; op = OP_AUIPC; end
            JAL:    begin fmt = FMT_J; op = OP_JAL;   end
            JALR:   begin fmt = FMT_I; op = OP_JALR;   f3 = F3_JALR; end
            BEQ:    begin fmt = FMT_B; op = OP_BRANCH; f3 = F3_BEQ;  end
            BNE:    begin fmt = FMT_B; op = OP_BRANCH; f3 = F3_BNE;  end
            BLT:    begin fmt = FMT_B; op = OP_BRANCH; f3 = F3_BLT;  end
            BGE:    begin fmt = FMT_B; op = OP_BRANCH; f3 = F3_BGE;  end
            BLTU:   begin fmt = FMT_B; op = OP_BRANCH; f3 = F3_BLTU; end
            BGEU:   begin fmt = FMT_B; op = OP_BRANCH; f3 = F3_BGEU; end
            LB:     begin fmt = FMT_I; op = OP_LOAD;   f3 = F3_B;    end
            LH:     begin fmt = FMT_I; op = OP_LOAD;   f3 = F3_H;    end
            LW:     begin fmt = FMT_I; op = OP_LOAD;   f3 = F3_W;    end
            LBU:    begin fmt = FMT_I; op = OP_LOAD;   f3 = F3_BU;   end
            LHU:    begin fmt = FMT_I; op = OP_LOAD;   f3 = F3_HU;   end
            SB:     begin fmt = FMT_S; op = OP_STORE;  f3 = F3_B;    end
            SH:     begin fmt = FMT_S; op = OP_STORE;  f3 = F3_H;    end
            SW:     begin fmt = FMT_S; op = OP_STORE;  f3 = F3_W;    end
            ADDI:   begin fmt = FMT_I;  op = OP_IMM; f3 = F3_ADD;  end
            SLTI:   begin fmt = FMT_I;  op = OP_IMM; f3 = F3_SLT;  end
            SLTIU:  begin fmt = FMT_I;  op = OP_IMM; f3 = F3_SLTU; end
            XORI:   begin fmt = FMT_I;  op = OP_IMM; f3 = F3_XOR;  end
            ORI:    begin fmt = FMT_I;  op = OP_IMM; f3 = F3_OR;   end
            ANDI:   begin fmt = FMT_I;  op = OP_IMM; f3 = F3_AND;  end
            SLLI:   begin fmt = FMT_SH; op = OP_IMM; f3 = F3_SLL;  end
            SRLI:   begin fmt = FMT_SH; op = OP_IMM; f3 = F3_SR;   end
            SRAI:   begin fmt = FMT_SH; op = OP_IMM; f3 = F3_SR; f7 = F7_ALT; end
            ADD:    begin fmt = FMT_R; f3 = F3_ADD;  end
            SUB:    begin fmt = FMT_R; f3 = F3_ADD;  f7 = F7_ALT; end
            SLL:    begin fmt = FMT_R; f3 = F3_SLL;  end
            SLT:    begin fmt = FMT_R; f3 = F3_SLT;  end
            SLTU:   begin fmt = FMT_R; f3 = F3_SLTU; end
            XOR:    begin fmt = FMT_R; f3 = F3_XOR;  end
            SRL:    begin fmt = FMT_R; f3 = F3_SR;   end
            SRA:    begin fmt = FMT_R; f3 = F3_SR;   f7 = F7_ALT; end
            OR:     begin fmt = FMT_R; f3 = F3_OR;   end
            AND:    begin fmt = FMT_R; f3 = F3_AND;  end
            ECALL:  begin fmt = FMT_SYS; op = OP_SYSTEM; end
            EBREAK: begin fmt = FMT_SYS; op = OP_SYSTEM; end
            default: fmt = FMT_NONE;
        endcase
    end

    // Assemble the word for the decoded layout and range-check its immediate.
    always_comb begin
        word    = '0;
        invalid = 1'b0;
        case (fmt)
            FMT_R:  word = {f7, rs2, rs1, f3, rd, op};
            FMT_I: begin
                word    = {imm[11:0], rs1, f3, rd, op};
                invalid = !fits_signed(imm, 12);
            end
            FMT_SH: word = {f7, imm[4:0], rs1, f3, rd, op};
            FMT_S: begin
                word    = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
                invalid = !fits_signed(imm, 12);
            end
            FMT_B: begin
                word    = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
                invalid = imm[0] || !fits_signed(imm, 13);
            end
            FMT_J: begin
                word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
                invalid = imm[0] || !fits_signed(imm, 21);
            end
            FMT_U:   word = {imm[31:12], rd, op};
            // Operand fields are deliberately ignored for environment calls.
            FMT_SYS: word = (mnemonic == EBREAK) ? EBREAK_WORD : ECALL_WORD;
            default: invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/rv32i_program_loader.sv
// Program loader: accepts instruction descriptors (valid/ready), encodes
// each into an RV32I word and writes it to consecutive memory words.
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both 1; the sender holds its fields stable while valid waits for ready.
module rv32i_program_loader
    import fe_pkg::*;
#(
    parameter int MEM_DEPTH = 64,
    parameter int AW        = $clog2(MEM_DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  RV32I_INSTRUCTION_MNEMONIC_t in_mnemonic,
    input  reg_idx_t                    in_rd,
    input  reg_idx_t                    in_rs1,
    input  reg_idx_t                    in_rs2,
    input  word_t                       in_imm,
    input  logic                        in_last,
    output logic                        mem_we,
    output logic [AW-1:0]               mem_addr,
    output word_t                       mem_wdata,
    input  logic                        mem_ready,
    output logic                        busy,
    output logic                        done,
    output logic                        err_invalid,
    output logic                        err_full,
    output logic [AW:0]                 count,
    output loader_state_t               fsm_state
);

    localparam logic [AW:0] FULL = (AW + 1)'(MEM_DEPTH);

    loader_state_t               state;
    RV32I_INSTRUCTION_MNEMONIC_t d_mnemonic;
    reg_idx_t                    d_rd;
    reg_idx_t                    d_rs1;
    reg_idx_t                    d_rs2;
    word_t                       d_imm;
    logic                        d_last;
    word_t                       enc_word;
    logic                        enc_invalid;
    logic [AW:0]                 count_inc;

    assign count_inc = count + 1'b1;
    assign mem_addr  = count[AW-1:0];
    assign fsm_state = state;

    rv32i_inst_encoder u_encoder (
        .mnemonic (d_mnemonic),
        .rd       (d_rd),
        .rs1      (d_rs1),
        .rs2      (d_rs2),
        .imm      (d_imm),
        .word     (enc_word),
        .invalid  (enc_invalid)
    );

    // Loader FSM with registered handshake, memory and status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_ready    <= 1'b0;
            mem_we      <= 1'b0;
            mem_wdata   <= '0;
            count       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_invalid <= 1'b0;
            err_full    <= 1'b0;
            d_mnemonic  <= NULL;
            d_rd        <= '0;
            d_rs1       <= '0;
            d_rs2       <= '0;
            d_imm       <= '0;
            d_last      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= ACCEPT;
                        busy        <= 1'b1;
                        in_ready    <= 1'b1;
                        count       <= '0;
                        err_invalid <= 1'b0;
                        err_full    <= 1'b0;
                    end
                end
                ACCEPT: begin
                    if (in_valid && in_ready) begin
                        d_mnemonic <= in_mnemonic;
                        d_rd       <= in_rd;
                        d_rs1      <= in_rs1;
                        d_rs2      <= in_rs2;
                        d_imm      <= in_imm;
                        d_last     <= in_last;
                        in_ready   <= 1'b0;
                        state      <= ENCODE;
                    end else if (in_valid && count == FULL) begin
                        // Memory already full: refuse and close the session.
                        err_full <= 1'b1;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                ENCODE: begin
                    if (enc_invalid) begin
                        // Dropped descriptor: nothing written, count unchanged.
                        err_invalid <= 1'b1;
                        if (d_last) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            in_ready <= (count < FULL);
                            state    <= ACCEPT;
                        end
                    end else begin
                        mem_wdata <= enc_word;
                        mem_we    <= 1'b1;
                        state     <= WRITE;
                    end
                end
                WRITE: begin
                    if (mem_ready) begin
                        mem_we <= 1'b0;
                        count  <= count_inc;
                        if (d_last) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            in_ready <= (count_inc < FULL);
                            state    <= ACCEPT;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_program_loader.sv
// Directed bench for rv32i_program_loader (MEM_DEPTH=4 so the full case
// is reachable quickly).
module tb_rv32i_program_loader;
    import fe_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic                        clk = 1'b0;
    logic                        rst_n = 1'b0;
    logic                        start = 1'b0;
    logic                        in_valid = 1'b0;
    logic                        in_ready;
    RV32I_INSTRUCTION_MNEMONIC_t in_mnemonic = NULL;
    reg_idx_t                    in_rd = '0;
    reg_idx_t                    in_rs1 = '0;
    reg_idx_t                    in_rs2 = '0;
    word_t                       in_imm = '0;
    logic                        in_last = 1'b0;
    logic                        mem_we;
    logic [AW-1:0]               mem_addr;
    word_t                       mem_wdata;
    logic                        mem_ready = 1'b1;
    logic                        busy;
    logic                        done;
    logic                        err_invalid;
    logic                        err_full;
    logic [AW:0]                 count;
    loader_state_t               fsm_state;

    int vectors = 0;
    int miscompares = 0;

    rv32i_program_loader #(.MEM_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_mnemonic (in_mnemonic),
        .in_rd       (in_rd),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_imm      (in_imm),
        .in_last     (in_last),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ready   (mem_ready),
        .busy        (busy),
        .done        (done),
        .err_invalid (err_invalid),
        .err_full    (err_full),
        .count       (count),
        .fsm_state   (fsm_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        chk("in_ready_wait", 32'(in_ready), 32'd1);
    endtask

    task automatic drive(input RV32I_INSTRUCTION_MNEMONIC_t mn, input reg_idx_t rd,
                         input reg_idx_t rs1, input reg_idx_t rs2,
                         input word_t imm, input logic last);
        in_valid    = 1'b1;
        in_mnemonic = mn;
        in_rd       = rd;
        in_rs1      = rs1;
        in_rs2      = rs2;
        in_imm      = imm;
        in_last     = last;
    endtask

    task automatic open_session();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_count", 32'(count), 32'd0);
        chk("start_err_invalid", 32'(err_invalid), 32'd0);
        chk("start_err_full", 32'(err_full), 32'd0);
    endtask

    // Valid descriptor with mem_ready held high: ENCODE cycle, WRITE cycle, then count.
    task automatic send_ok(input RV32I_INSTRUCTION_MNEMONIC_t mn, input reg_idx_t rd,
                           input reg_idx_t rs1, input reg_idx_t rs2, input word_t imm,
                           input logic last, input word_t exp_word, input int exp_addr);
        wait_ready();
        drive(mn, rd, rs1, rs2, imm, last);
        tick();
        in_valid = 1'b0;
        chk("encode_in_ready", 32'(in_ready), 32'd0);
        chk("encode_mem_we", 32'(mem_we), 32'd0);
        tick();
        chk("write_mem_we", 32'(mem_we), 32'd1);
        chk("write_addr", 32'(mem_addr), 32'(exp_addr));
        chk("write_wdata", mem_wdata, exp_word);
        tick();
        chk("after_write_mem_we", 32'(mem_we), 32'd0);
        chk("after_write_count", 32'(count), 32'(exp_addr + 1));
    endtask

    // Invalid descriptor: dropped after ENCODE, no write, count unchanged.
    task automatic send_bad(input RV32I_INSTRUCTION_MNEMONIC_t mn, input word_t imm,
                            input logic last, input int exp_count);
        wait_ready();
        drive(mn, 5'd1, 5'd2, 5'd3, imm, last);
        tick();
        in_valid = 1'b0;
        chk("bad_encode_mem_we", 32'(mem_we), 32'd0);
        tick();
        chk("bad_mem_we", 32'(mem_we), 32'd0);
        chk("bad_err_invalid", 32'(err_invalid), 32'd1);
        chk("bad_count", 32'(count), 32'(exp_count));
    endtask

    task automatic expect_done_then_idle();
        chk("done_high", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd1);
        tick();
        chk("done_low", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_in_ready", 32'(in_ready), 32'd0);
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err_invalid", 32'(err_invalid), 32'd0);
        chk("rst_err_full", 32'(err_full), 32'd0);
        rst_n = 1'b1;
        tick();

        // ADDI x1,x0,5
        open_session();
        chk("accept_in_ready", 32'(in_ready), 32'd1);
        send_ok(ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h0050_0093, 0);
        expect_done_then_idle();

        // start ignored outside IDLE is exercised below; R/S/shift words
        open_session();
        send_ok(ADD,  5'd3, 5'd1, 5'd2, 32'd0, 1'b0, 32'h0020_81B3, 0);
        start = 1'b1;
        send_ok(SW,   5'd0, 5'd1, 5'd2, 32'd8, 1'b0, 32'h0020_A423, 1);
        start = 1'b0;
        send_ok(SRAI, 5'd5, 5'd6, 5'd0, 32'd3, 1'b0, 32'h4033_5293, 2);
        send_ok(SUB,  5'd1, 5'd2, 5'd3, 32'd0, 1'b1, 32'h4031_00B3, 3);
        expect_done_then_idle();

        // Branch, jump, upper immediate, EBREAK with junk operands
        open_session();
        send_ok(BEQ,    5'd0,  5'd1,  5'd2,  32'd8,         1'b0, 32'h0020_8463, 0);
        send_ok(JAL,    5'd1,  5'd0,  5'd0,  32'd16,        1'b0, 32'h0100_00EF, 1);
        send_ok(LUI,    5'd5,  5'd0,  5'd0,  32'h1234_5000, 1'b0, 32'h1234_52B7, 2);
        send_ok(EBREAK, 5'd31, 5'd17, 5'd9,  32'hFFFF_FFFF, 1'b1, 32'h0010_0073, 3);
        expect_done_then_idle();

        // Invalid descriptors: NULL mnemonic, misaligned branch offset
        open_session();
        send_bad(NULL, 32'd0, 1'b0, 0);
        send_bad(BEQ,  32'd3, 1'b1, 0);
        expect_done_then_idle();
        chk("err_invalid_sticky", 32'(err_invalid), 32'd1);

        // Fill the 4-word memory, then a 5th descriptor trips err_full
        open_session();
        send_ok(ADDI, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0, 32'h0010_0093, 0);
        send_ok(ADDI, 5'd2, 5'd0, 5'd0, 32'd2, 1'b0, 32'h0020_0113, 1);
        send_ok(ADDI, 5'd3, 5'd0, 5'd0, 32'd3, 1'b0, 32'h0030_0193, 2);
        send_ok(ADDI, 5'd4, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b0, 32'hFFF0_0213, 3);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        drive(ADDI, 5'd5, 5'd0, 5'd0, 32'd5, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("full_err_full", 32'(err_full), 32'd1);
        chk("full_count", 32'(count), 32'd4);
        chk("full_mem_we", 32'(mem_we), 32'd0);
        expect_done_then_idle();
        chk("err_full_sticky", 32'(err_full), 32'd1);

        // Stalled write held stable, then reset mid-WRITE
        open_session();
        send_ok(ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 32'h0050_0093, 0);
        mem_ready = 1'b0;
        wait_ready();
        drive(ADD, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_mem_we", 32'(mem_we), 32'd1);
            chk("stall_addr", 32'(mem_addr), 32'd1);
            chk("stall_wdata", mem_wdata, 32'h0020_81B3);
            chk("stall_count", 32'(count), 32'd1);
        end
        rst_n = 1'b0;
        tick();
        chk("wrst_mem_we", 32'(mem_we), 32'd0);
        chk("wrst_count", 32'(count), 32'd0);
        chk("wrst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        mem_ready = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
